// File: rtl/add_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : add_disp_pkg
//  Description : Shared types, constants and hex font for the switch-adder
//                display controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package add_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [1:0] MODE_ADD  = 2'b10;

    // Active-low seven-segment font, bit 0 = segment a ... bit 6 = segment g
    function automatic logic [6:0] hex_to_seg(input logic [3:0] i_hex);
        logic [6:0] w_seg;
        case (i_hex)
            4'h0:    w_seg = 7'b1000000;
            4'h1:    w_seg = 7'b1111001;
            4'h2:    w_seg = 7'b0100100;
            4'h3:    w_seg = 7'b0110000;
            4'h4:    w_seg = 7'b0011001;
            4'h5:    w_seg = 7'b0010010;
            4'h6:    w_seg = 7'b0000010;
            4'h7:    w_seg = 7'b1111000;
            4'h8:    w_seg = 7'b0000000;
            4'h9:    w_seg = 7'b0010000;
            4'hA:    w_seg = 7'b0001000;
            4'hB:    w_seg = 7'b0000011;
            4'hC:    w_seg = 7'b1000110;
            4'hD:    w_seg = 7'b0100001;
            4'hE:    w_seg = 7'b0000110;
            default: w_seg = 7'b0001110;
        endcase
        return w_seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_disp_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : add_disp_ctrl_if
//  Description : Board-side bundle: switches, push-button and the
//                seven-segment display pins.
//  Revision    : 1.0 - initial release
// ============================================================================
interface add_disp_ctrl_if;
    logic [15:0] sw;
    logic        btnL;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    // Board / stimulus side
    modport master (output sw, output btnL, input seg, input an, input dp);
    // Controller side
    modport slave  (input sw, input btnL, output seg, output an, output dp);
endinterface
`default_nettype wire

// File: rtl/add_disp_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchronizer, consecutive-sample debouncer and
//                rising-edge press pulse for a raw push-button.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_btn,
    output logic      o_level,
    output logic      o_press
);

    localparam int             CW        = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0]  c_CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;
    logic          r_armed;
    logic          w_sync;

    assign w_sync = r_sync[1];

    // Synchronizer resets high so a button held through reset is treated as
    // already pressed; it must be seen low before a press can be reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    // Debounce counter: level flips after DEBOUNCE_CYC disagreeing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_sync == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Edge-detect delay and arming once a released button has been observed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_level_d <= r_level;
            if (!w_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_level & ~r_level_d & r_armed;

endmodule
`default_nettype wire

// File: rtl/add_disp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : add_disp_ctrl
//  Description : Captures two 4-bit switch operands on a debounced btnL press
//                in add mode, adds them, and scans sum, carry and operands
//                across the four-digit seven-segment display.
//                Option macro ADD_DISP_CARRY_DP_EN: carry shown on the digit-0
//                decimal point and digit 1 blanked.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_disp_ctrl
    import add_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    add_disp_ctrl_if.slave bus
);

    localparam int             DW        = $clog2(REFRESH_DIV);
    localparam logic [DW-1:0]  c_DIV_MAX = DW'(REFRESH_DIV - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic          w_capture;
    logic          w_level;
    logic          w_press;
    logic          w_mode_add;

    logic [3:0]    r_a;
    logic [3:0]    r_b;
    logic [4:0]    r_sum;
    logic          r_valid;

    logic [DW-1:0] r_div;
    logic [1:0]    r_idx;

    logic [3:0]    w_digit;
    logic [6:0]    w_seg_nxt;
    logic [3:0]    w_an_nxt;
    logic          w_dp_nxt;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_dp;

    assign w_mode_add = (bus.sw[15:14] == MODE_ADD);

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (bus.btnL),
        .o_level (w_level),
        .o_press (w_press)
    );

    // Capture FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture FSM next state: presses outside add mode are ignored
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_press && w_mode_add) w_state_next = CALC;
            CALC:    w_state_next = HOLD;
            HOLD:    if (!w_level) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Capture FSM outputs
    always_comb begin
        w_capture = (r_state == CALC);
    end

    // Operand and sum registers, written only in CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_sum   <= 5'd0;
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_a     <= bus.sw[3:0];
            r_b     <= bus.sw[7:4];
            r_sum   <= {1'b0, bus.sw[3:0]} + {1'b0, bus.sw[7:4]};
            r_valid <= 1'b1;
        end
    end

    // Slot timer and digit index; index 0 gets a full slot after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= 2'd0;
        end else if (r_div == c_DIV_MAX) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Digit content for the current index
    always_comb begin
        w_digit = 4'h0;
        case (r_idx)
            2'd0:    w_digit = r_sum[3:0];
            2'd1:    w_digit = {3'b000, r_sum[4]};
            2'd2:    w_digit = r_a;
            default: w_digit = r_b;
        endcase
    end

    // Display decode: blank outside add mode, dashes until a capture
    always_comb begin
        w_an_nxt  = ~(4'b0001 << r_idx);
        w_seg_nxt = hex_to_seg(w_digit);
        w_dp_nxt  = 1'b1;
        if (!w_mode_add) begin
            w_an_nxt  = 4'b1111;
            w_seg_nxt = SEG_BLANK;
        end else if (!r_valid) begin
            w_seg_nxt = SEG_DASH;
        end else begin
`ifdef ADD_DISP_CARRY_DP_EN
            if (r_idx == 2'd1) begin
                w_seg_nxt = SEG_BLANK;
            end
            if (r_idx == 2'd0) begin
                w_dp_nxt = ~r_sum[4];
            end
`endif
        end
    end

    // Registered pins so anode and cathodes always switch on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= 4'b1111;
            r_dp  <= 1'b1;
        end else begin
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign bus.seg = r_seg;
    assign bus.an  = r_an;
    assign bus.dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_add_disp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_disp_ctrl
//  Description : Self-checking bench for add_disp_ctrl with a scoreboard of
//                expected display slots.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_disp_ctrl;

    localparam int RD = 4;
    localparam int DC = 8;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_disp_ctrl_if bus ();

    add_disp_ctrl #(
        .REFRESH_DIV  (RD),
        .DEBOUNCE_CYC (DC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    errors = 0;
    int    checks = 0;
    disp_t exp_q[$];

    logic [3:0] m_a;
    logic [3:0] m_b;
    logic       m_valid;

    function automatic logic [6:0] font(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000; 4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100; 4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001; 4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010; 4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000; 4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000; 4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110; 4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110; default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed={an,seg,dp}=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop one expectation and compare against the pins right now
    task automatic expect_now(input string tag);
        disp_t e;
        e = exp_q.pop_front();
        chk(tag, {bus.an, bus.seg, bus.dp}, e);
    endtask

    task automatic push_blank4();
        for (int k = 0; k < 4; k++) exp_q.push_back({4'b1111, 7'b1111111, 1'b1});
    endtask

    // Expected four slots (digit 0..3) from the bench's own operand model
    task automatic push_frame();
        logic [4:0] s;
        disp_t      e;
        s = {1'b0, m_a} + {1'b0, m_b};
        for (int d = 0; d < 4; d++) begin
            e.an    = 4'b1111;
            e.an[d] = 1'b0;
            e.dp    = 1'b1;
            if (!m_valid) begin
                e.seg = 7'b0111111;
            end else begin
                case (d)
                    0:       e.seg = font(s[3:0]);
                    1:       e.seg = font({3'b000, s[4]});
                    2:       e.seg = font(m_a);
                    default: e.seg = font(m_b);
                endcase
`ifdef ADD_DISP_CARRY_DP_EN
                if (d == 1) e.seg = 7'b1111111;
                if (d == 0) e.dp  = ~s[4];
`endif
            end
            exp_q.push_back(e);
        end
    endtask

    // Align to the start of a digit-0 slot, then check each slot in turn
    task automatic frame_check(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.an != 4'b0111 && n < 64) begin @(negedge clk); n++; end
        while (bus.an == 4'b0111 && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout observed an=%b expected scan to reach digit 0", tag, bus.an);
            exp_q.delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                expect_now($sformatf("%s_d%0d", tag, k));
                repeat (RD) @(negedge clk);
            end
        end
    endtask

    task automatic blank_check(input string tag);
        push_blank4();
        for (int k = 0; k < 4; k++) begin
            repeat (RD) @(negedge clk);
            expect_now($sformatf("%s_%0d", tag, k));
        end
    endtask

    task automatic press(input int n);
        bus.btnL = 1'b1;
        repeat (n) @(negedge clk);
        bus.btnL = 1'b0;
    endtask

    initial begin
        bus.sw   = 16'h8000;
        bus.btnL = 1'b0;
        m_a = 4'd0; m_b = 4'd0; m_valid = 1'b0;
        rst_n = 1'b0;

        // Reset values while held
        repeat (3) @(negedge clk);
        exp_q.push_back({4'b1111, 7'b1111111, 1'b1});
        expect_now("reset");

        // Release: dashes scanned from digit 0, four cycles per digit
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++)
            exp_q.push_back({~(4'b0001 << (k / 4)), 7'b0111111, 1'b1});
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            expect_now($sformatf("scan%0d", k));
        end

        // Bouncing button: never stable long enough
        for (int i = 0; i < 10; i++) begin
            bus.btnL = ~bus.btnL;
            repeat (3) @(negedge clk);
        end
        bus.btnL = 1'b0;
        repeat (20) @(negedge clk);
        push_frame();
        frame_check("bounce");

        // Short 6-cycle pulse rejected
        press(6);
        repeat (20) @(negedge clk);
        push_frame();
        frame_check("pulse6");

        // Press outside add mode: no capture, display blanked
        bus.sw = 16'h4035;
        press(12);
        repeat (15) @(negedge clk);
        blank_check("mode01");
        bus.sw = 16'h8035;
        push_frame();
        frame_check("mode10_dash");

        // Add 5 + 3
        press(12);
        m_a = 4'h5; m_b = 4'h3; m_valid = 1'b1;
        repeat (15) @(negedge clk);
        push_frame();
        frame_check("add53");

        // Switches changed during HOLD do not disturb the display
        bus.sw   = 16'h8012;
        bus.btnL = 1'b1;
        repeat (16) @(negedge clk);
        m_a = 4'h2; m_b = 4'h1;
        bus.sw = 16'h80CA;
        push_frame();
        frame_check("hold_sw");
        bus.btnL = 1'b0;
        repeat (15) @(negedge clk);

        // Leaving add mode blanks; returning shows the retained values
        bus.sw = 16'h40CA;
        repeat (2) @(negedge clk);
        blank_check("retain_blank");
        bus.sw = 16'h80CA;
        push_frame();
        frame_check("retain");

        // Overflow F + F = 30
        bus.sw = 16'h80FF;
        press(12);
        m_a = 4'hF; m_b = 4'hF;
        repeat (15) @(negedge clk);
        push_frame();
        frame_check("ovf");

        // Reset mid-HOLD with the button still held
        bus.sw   = 16'h8034;
        bus.btnL = 1'b1;
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        #2;
        exp_q.push_back({4'b1111, 7'b1111111, 1'b1});
        expect_now("rst_hold");
        m_a = 4'd0; m_b = 4'd0; m_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        push_frame();
        frame_check("rst_nocap");

        // Release, then a fresh press captures again
        bus.btnL = 1'b0;
        repeat (20) @(negedge clk);
        bus.sw = 16'h8096;
        press(12);
        m_a = 4'h6; m_b = 4'h9; m_valid = 1'b1;
        repeat (15) @(negedge clk);
        push_frame();
        frame_check("repress");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
